axi_stream_packet_tx: RTL

//  AXI4-Stream transmitter (master end of axi_stream_if). Local logic writes up to MAX_BEATS data_t words

---
 rtl/axi_stream_packet_tx_if.sv | 29 ++
 rtl/axi_stream_packet_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/axi_stream_packet_tx_if.sv
// Shared AXI4-Stream word type and the stream interface with master/slave views.
// Kept in one file so the type is always declared before the interface that uses it.

package axi_stream_pkg;
    typedef logic [31:0] data_t;
endpackage

interface axi_stream_if;
    import axi_stream_pkg::*;

    data_t tdata;
    logic  tvalid;
    logic  tlast;
    logic  tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axi_stream_packet_tx.sv
// Buffered AXI4-Stream packet transmitter: words are loaded locally, then a start pulse
// streams the first pkt_len of them with tlast on the final beat.

module axi_stream_packet_tx
    import axi_stream_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 8,
    parameter int unsigned LEN_W     = $clog2(MAX_BEATS) + 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             areset_n,

    input  logic             load_valid_i,
    input  data_t            load_data_i,
    output logic             load_ready_o,

    input  logic             start_i,
    input  logic [LEN_W-1:0] pkt_len_i,

    output logic             busy_o,
    output logic             done_o,
    output logic             start_err_o,
    output logic [CNT_W-1:0] pkt_count_o,

    axi_stream_if.master     m_axi_stream
);

    localparam int unsigned      IDX_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [LEN_W-1:0] MaxBeatsL = LEN_W'(MAX_BEATS);

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             start_err_q, start_err_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

    data_t            buf_q [MAX_BEATS];

    logic             load_fire;
    logic             beat_fire;
    logic             is_last;
    logic [LEN_W-1:0] eff_len;

    // load_ready is gated by the raw reset so it reads 0 while reset is held.
    always_comb begin
        load_ready_o = areset_n && (state_q == StIdle) && (fill_cnt_q < MaxBeatsL);
        load_fire    = load_valid_i && load_ready_o;
        eff_len      = fill_cnt_q + LEN_W'(load_fire);
        is_last      = (rd_ptr_q == (len_q - LEN_W'(1)));
        beat_fire    = (state_q == StSend) && m_axi_stream.tready;
    end

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        done_d      = 1'b0;
        start_err_d = 1'b0;
        pkt_count_d = pkt_count_q;

        unique case (state_q)
            StIdle: begin
                if (load_fire) begin
                    fill_cnt_d = fill_cnt_q + LEN_W'(1);
                end
                if (start_i) begin
                    if ((pkt_len_i == '0) || (pkt_len_i > eff_len)) begin
                        start_err_d = 1'b1;
                    end else begin
                        len_d    = pkt_len_i;
                        rd_ptr_d = '0;
                        state_d  = StSend;
                    end
                end
            end
            StSend: begin
                if (beat_fire) begin
                    rd_ptr_d = rd_ptr_q + LEN_W'(1);
                    if (is_last) begin
                        // Unsent words are dropped; the next packet starts from buffer[0].
                        state_d     = StIdle;
                        fill_cnt_d  = '0;
                        done_d      = 1'b1;
                        pkt_count_d = pkt_count_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= StIdle;
            fill_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            len_q       <= '0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (load_fire) begin
            buf_q[fill_cnt_q[IDX_W-1:0]] <= load_data_i;
        end
    end

    // tvalid comes straight from the state register so it never depends on tready.
    assign m_axi_stream.tvalid = (state_q == StSend);
    assign m_axi_stream.tlast  = (state_q == StSend) && is_last;
    assign m_axi_stream.tdata  = buf_q[rd_ptr_q[IDX_W-1:0]];

    assign busy_o      = (state_q == StSend);
    assign done_o      = done_q;
    assign start_err_o = start_err_q;
    assign pkt_count_o = pkt_count_q;

endmodule
